// File: rtl/engine_multi_shooter.sv
// Invaders game engine: game-state FSM, row-weighted kill score and N independent
// enemy-fire channels that shoot from the bottom-most live enemy of an LFSR-chosen column.
module engine_multi_shooter #(
    parameter int ROWS        = 5,
    parameter int COLS        = 13,
    parameter int N_SHOOTERS  = 2,
    parameter int FIRE_PERIOD = 1000000,
    parameter int SCORE_W     = 10
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                btn_D,
    input  logic [ROWS*COLS-1:0]                enemy_vivos,
    input  logic                                jogador_vivo,
    input  logic                                vitoria_enemy,
    input  logic [N_SHOOTERS-1:0]               shot_busy,
    output logic                                restart,
    output logic [1:0]                          estado_jogo,
    output logic [SCORE_W-1:0]                  score,
    output logic [N_SHOOTERS-1:0]               fire_valid,
    output logic [N_SHOOTERS*$clog2(COLS)-1:0]  fire_col,
    output logic [N_SHOOTERS*$clog2(ROWS)-1:0]  fire_row
);
    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int CHW = (N_SHOOTERS > 1) ? $clog2(N_SHOOTERS) : 1;
    localparam int TW  = $clog2(FIRE_PERIOD);

    typedef enum logic [1:0] {PLAYING = 2'd1, WON = 2'd2, LOST = 2'd3} game_t;
    typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} sel_t;

    game_t                     game_state, game_next;
    sel_t                      sel_state, sel_next;
    logic [SCORE_W-1:0]        kill_sum;
    logic [15:0]               lfsr;
    logic [TW-1:0]             timer;
    logic                      playing, tick;
    logic [CW-1:0]             sel_col, col_next, start_col;
    logic [CW-1:0]             sel_cnt, cnt_next;
    logic [CHW-1:0]            sel_ch, ch_next, free_ch;
    logic                      free_found, col_live;
    logic [RW-1:0]             row_hit;
    logic [N_SHOOTERS-1:0]     fv_next;
    logic [N_SHOOTERS*CW-1:0]  fc_next;
    logic [N_SHOOTERS*RW-1:0]  fr_next;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign restart     = reset | ~btn_D;
    assign estado_jogo = game_state;
    assign playing     = (game_state == PLAYING);
    assign tick        = playing && (timer == TW'(FIRE_PERIOD - 1));
    // Scales the 16-bit LFSR into 0..COLS-1 without a modulo.
    assign start_col   = CW'((32'(lfsr) * 32'(COLS)) >> 16);

    always_comb begin
        game_next = game_state;
        if (game_state == PLAYING) begin
            if (vitoria_enemy || !jogador_vivo)
                game_next = LOST;
            else if (enemy_vivos == '0)
                game_next = WON;
        end
    end

    always_comb begin
        kill_sum = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!enemy_vivos[r*COLS + c])
                    kill_sum = kill_sum + SCORE_W'(ROWS - r);
    end

    always_comb begin
        free_found = 1'b0;
        free_ch    = '0;
        for (int k = N_SHOOTERS - 1; k >= 0; k--)
            if (!shot_busy[k]) begin
                free_found = 1'b1;
                free_ch    = CHW'(k);
            end
    end

    // Ascending row scan leaves the bottom-most live enemy in row_hit.
    always_comb begin
        col_live = 1'b0;
        row_hit  = '0;
        for (int r = 0; r < ROWS; r++)
            if (enemy_vivos[r*COLS + int'(sel_col)]) begin
                col_live = 1'b1;
                row_hit  = RW'(r);
            end
    end

    always_comb begin
        sel_next = sel_state;
        col_next = sel_col;
        cnt_next = sel_cnt;
        ch_next  = sel_ch;
        fv_next  = '0;
        fc_next  = fire_col;
        fr_next  = fire_row;
        case (sel_state)
            S_IDLE: begin
                if (tick && free_found) begin
                    sel_next = S_SCAN;
                    col_next = start_col;
                    cnt_next = '0;
                    ch_next  = free_ch;
                end
            end
            S_SCAN: begin
                if (game_next != PLAYING) begin
                    sel_next = S_IDLE;
                end else if (col_live) begin
                    fv_next[sel_ch]                   = 1'b1;
                    fc_next[int'(sel_ch)*CW +: CW]    = sel_col;
                    fr_next[int'(sel_ch)*RW +: RW]    = row_hit;
                    sel_next                          = S_IDLE;
                end else if (sel_cnt == CW'(COLS - 1)) begin
                    sel_next = S_IDLE;
                end else begin
                    col_next = (sel_col == CW'(COLS - 1)) ? '0 : sel_col + CW'(1);
                    cnt_next = sel_cnt + CW'(1);
                end
            end
            default: sel_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            game_state <= PLAYING;
            score      <= '0;
            lfsr       <= 16'hACE1;
            timer      <= '0;
            sel_state  <= S_IDLE;
            sel_col    <= '0;
            sel_cnt    <= '0;
            sel_ch     <= '0;
            fire_valid <= '0;
            fire_col   <= '0;
            fire_row   <= '0;
        end else begin
            game_state <= game_next;
            if (playing) begin
                score <= kill_sum;
                timer <= (timer == TW'(FIRE_PERIOD - 1)) ? '0 : timer + TW'(1);
            end
            lfsr       <= lfsr_step(lfsr);
            sel_state  <= sel_next;
            sel_col    <= col_next;
            sel_cnt    <= cnt_next;
            sel_ch     <= ch_next;
            fire_valid <= fv_next;
            fire_col   <= fc_next;
            fire_row   <= fr_next;
        end
    end
endmodule
